// File: rtl/wb_sram_arbiter_2m.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_sram_arbiter_2m                                           |
// | Description : Two-master Wishbone arbiter in front of the SRAM bridge.     |
// |               Grants one master per CYC-held bus cycle, alternates         |
// |               round-robin under contention, and turns a stalled STB into   |
// |               a one-cycle ERR after TIMEOUT cycles without a response.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_sram_arbiter_2m #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    // master 0
    input  logic [ADDRESS_WIDTH-1:0]  m0_adr,
    input  logic [DATA_WIDTH-1:0]     m0_dat_w,
    output logic [DATA_WIDTH-1:0]     m0_dat_r,
    input  logic                      m0_cyc,
    input  logic                      m0_stb,
    input  logic                      m0_we,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel,
    output logic                      m0_ack,
    output logic                      m0_err,
    // master 1
    input  logic [ADDRESS_WIDTH-1:0]  m1_adr,
    input  logic [DATA_WIDTH-1:0]     m1_dat_w,
    output logic [DATA_WIDTH-1:0]     m1_dat_r,
    input  logic                      m1_cyc,
    input  logic                      m1_stb,
    input  logic                      m1_we,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel,
    output logic                      m1_ack,
    output logic                      m1_err,
    // downstream slave
    output logic [ADDRESS_WIDTH-1:0]  s_adr,
    output logic [DATA_WIDTH-1:0]     s_dat_w,
    input  logic [DATA_WIDTH-1:0]     s_dat_r,
    output logic                      s_cyc,
    output logic                      s_stb,
    output logic                      s_we,
    output logic [DATA_WIDTH/8-1:0]   s_sel,
    input  logic                      s_ack,
    input  logic                      s_err,
    // one-hot grant {m1,m0}
    output logic [1:0]                gnt
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    // index of the master most recently granted; 1 so m0 wins first contention
    logic       r_last;
    logic       w_last_nxt;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_any_gnt;
    logic       w_g_cyc;
    logic       w_g_stb;
    logic       w_to_fire;

    assign w_gnt0    = (r_state == c_GNT0);
    assign w_gnt1    = (r_state == c_GNT1);
    assign w_any_gnt = w_gnt0 | w_gnt1;
    assign w_g_cyc   = w_gnt0 ? m0_cyc : (w_gnt1 ? m1_cyc : 1'b0);
    assign w_g_stb   = w_gnt0 ? m0_stb : (w_gnt1 ? m1_stb : 1'b0);

    // State and round-robin history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Grant selection: hold while owner keeps CYC, hand over directly on release
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            c_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    w_state_nxt = r_last ? c_GNT0 : c_GNT1;
                end else if (m0_cyc) begin
                    w_state_nxt = c_GNT0;
                end else if (m1_cyc) begin
                    w_state_nxt = c_GNT1;
                end
            end
            c_GNT0: begin
                if (!m0_cyc) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = m1_cyc ? c_GNT1 : c_IDLE;
                end
            end
            c_GNT1: begin
                if (!m1_cyc) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = m0_cyc ? c_GNT0 : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int           c_TW         = $clog2(TIMEOUT + 1);
            localparam logic [c_TW-1:0] c_TCNT_LAST = c_TW'(TIMEOUT - 1);
            localparam logic [c_TW-1:0] c_TCNT_ONE  = c_TW'(1);

            logic [c_TW-1:0] r_tcnt;

            // Fires on the last allowed stalled cycle unless the slave answers in it
            assign w_to_fire = (r_tcnt == c_TCNT_LAST) & w_g_stb & ~s_ack & ~s_err;

            // Count consecutive granted-STB cycles that see no ACK/ERR
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tcnt <= '0;
                end else if (!w_any_gnt || !w_g_stb || s_ack || s_err || w_to_fire) begin
                    r_tcnt <= '0;
                end else begin
                    r_tcnt <= r_tcnt + c_TCNT_ONE;
                end
            end
        end else begin : g_no_timeout
            assign w_to_fire = 1'b0;
        end
    endgenerate

    // Forward path; IDLE presents m0's qualifiers with CYC/STB low
    assign s_adr   = w_gnt1 ? m1_adr   : m0_adr;
    assign s_dat_w = w_gnt1 ? m1_dat_w : m0_dat_w;
    assign s_we    = w_gnt1 ? m1_we    : m0_we;
    assign s_sel   = w_gnt1 ? m1_sel   : m0_sel;
    assign s_cyc   = w_g_cyc;
    // the timed-out strobe is withheld so the slave never sees a request the master abandons
    assign s_stb   = w_g_stb & ~w_to_fire;

    // Return path
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign m0_ack   = w_gnt0 & s_ack;
    assign m0_err   = w_gnt0 & (s_err | w_to_fire);
    assign m1_ack   = w_gnt1 & s_ack;
    assign m1_err   = w_gnt1 & (s_err | w_to_fire);

    assign gnt = {w_gnt1, w_gnt0};

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_arbiter_2m.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_sram_arbiter_2m                                        |
// | Description : Self-checking bench for wb_sram_arbiter_2m. One instance     |
// |               with TIMEOUT=4 and one with TIMEOUT=0 share the stimulus and |
// |               are compared each cycle against a behavioural model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_sram_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cyc = 2'b00;
    logic [1:0]    stb = 2'b00;
    logic [1:0]    we  = 2'b00;
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] datw [2];
    logic [SW-1:0] sel  [2];
    logic          s_ack = 1'b0;
    logic          s_err = 1'b0;
    logic [DW-1:0] s_dat_r = '0;

    logic [DW-1:0] a_m0_dat_r, a_m1_dat_r, a_s_dat_w;
    logic [AW-1:0] a_s_adr;
    logic          a_s_cyc, a_s_stb, a_s_we;
    logic [SW-1:0] a_s_sel;
    logic          a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
    logic [1:0]    a_gnt;

    logic [DW-1:0] b_m0_dat_r, b_m1_dat_r, b_s_dat_w;
    logic [AW-1:0] b_s_adr;
    logic          b_s_cyc, b_s_stb, b_s_we;
    logic [SW-1:0] b_s_sel;
    logic          b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic [1:0]    b_gnt;

    // model state: owner (-1 none), last granted master, stalled-STB count
    int   own = -1;
    int   lst = 1;
    int   wt  = 0;
    logic m_gstb = 1'b0;
    logic m_fire = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] errv;
    logic       errb;

    always #5 clk = ~clk;

    wb_sram_arbiter_2m #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst),
        .m0_adr(adr[0]), .m0_dat_w(datw[0]), .m0_dat_r(a_m0_dat_r), .m0_cyc(cyc[0]),
        .m0_stb(stb[0]), .m0_we(we[0]), .m0_sel(sel[0]), .m0_ack(a_m0_ack), .m0_err(a_m0_err),
        .m1_adr(adr[1]), .m1_dat_w(datw[1]), .m1_dat_r(a_m1_dat_r), .m1_cyc(cyc[1]),
        .m1_stb(stb[1]), .m1_we(we[1]), .m1_sel(sel[1]), .m1_ack(a_m1_ack), .m1_err(a_m1_err),
        .s_adr(a_s_adr), .s_dat_w(a_s_dat_w), .s_dat_r(s_dat_r), .s_cyc(a_s_cyc),
        .s_stb(a_s_stb), .s_we(a_s_we), .s_sel(a_s_sel), .s_ack(s_ack), .s_err(s_err),
        .gnt(a_gnt)
    );

    wb_sram_arbiter_2m #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_adr(adr[0]), .m0_dat_w(datw[0]), .m0_dat_r(b_m0_dat_r), .m0_cyc(cyc[0]),
        .m0_stb(stb[0]), .m0_we(we[0]), .m0_sel(sel[0]), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
        .m1_adr(adr[1]), .m1_dat_w(datw[1]), .m1_dat_r(b_m1_dat_r), .m1_cyc(cyc[1]),
        .m1_stb(stb[1]), .m1_we(we[1]), .m1_sel(sel[1]), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
        .s_adr(b_s_adr), .s_dat_w(b_s_dat_w), .s_dat_r(s_dat_r), .s_cyc(b_s_cyc),
        .s_stb(b_s_stb), .s_we(b_s_we), .s_sel(b_s_sel), .s_ack(s_ack), .s_err(s_err),
        .gnt(b_gnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // compare every output of both instances against the model at mid-cycle
    task automatic check_all();
        logic          e_cyc;
        logic [1:0]    e_gnt;
        int            oi;
        @(negedge clk);
        if (rst) begin
            own = -1; lst = 1; wt = 0;
        end
        m_gstb = 1'b0;
        e_cyc  = 1'b0;
        if (own >= 0) begin
            m_gstb = stb[own];
            e_cyc  = cyc[own];
        end
        m_fire = (own >= 0) && m_gstb && !s_ack && !s_err && (wt == TO - 1);
        oi     = (own == 1) ? 1 : 0;
        e_gnt  = (own == 0) ? 2'b01 : ((own == 1) ? 2'b10 : 2'b00);

        check("a_gnt",    a_gnt,    e_gnt);
        check("a_s_cyc",  a_s_cyc,  e_cyc);
        check("a_s_stb",  a_s_stb,  m_gstb && !m_fire);
        check("a_s_adr",  a_s_adr,  adr[oi]);
        check("a_s_dat_w", a_s_dat_w, datw[oi]);
        check("a_s_we",   a_s_we,   we[oi]);
        check("a_s_sel",  a_s_sel,  sel[oi]);
        check("a_m0_ack", a_m0_ack, (own == 0) && s_ack);
        check("a_m1_ack", a_m1_ack, (own == 1) && s_ack);
        check("a_m0_err", a_m0_err, (own == 0) && (s_err || m_fire));
        check("a_m1_err", a_m1_err, (own == 1) && (s_err || m_fire));
        check("a_m0_dat_r", a_m0_dat_r, s_dat_r);
        check("a_m1_dat_r", a_m1_dat_r, s_dat_r);
        check("b_gnt",    b_gnt,    e_gnt);
        check("b_s_stb",  b_s_stb,  m_gstb);
        check("b_m0_err", b_m0_err, (own == 0) && s_err);
        check("b_m1_err", b_m1_err, (own == 1) && s_err);
        check("b_m1_ack", b_m1_ack, (own == 1) && s_ack);
    endtask

    // advance the model across one rising edge, then step just past it
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            own = -1; lst = 1; wt = 0;
        end else begin
            if (own < 0 || !m_gstb || s_ack || s_err || m_fire) wt = 0;
            else wt = wt + 1;
            if (own < 0) begin
                if (cyc[0] && cyc[1]) own = (lst == 1) ? 0 : 1;
                else if (cyc[0])      own = 0;
                else if (cyc[1])      own = 1;
            end else if (!cyc[own]) begin
                lst = own;
                own = cyc[1-own] ? (1 - own) : -1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        check_all();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 2'b00; stb = 2'b00; s_ack = 1'b0; s_err = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic rand_inputs(input int ack_pct, input int stb_pct);
        for (int i = 0; i < 2; i++) begin
            if (cyc[i]) begin
                if ($urandom_range(0, 4) == 0) cyc[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                cyc[i] = 1'b1;
            end
            stb[i]  = cyc[i] && ($urandom_range(0, 99) < stb_pct);
            we[i]   = 1'($urandom);
            adr[i]  = $urandom;
            datw[i] = $urandom;
            sel[i]  = SW'($urandom);
        end
        s_ack   = ($urandom_range(0, 99) < ack_pct);
        s_err   = (ack_pct > 0) && ($urandom_range(0, 19) == 0);
        s_dat_r = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; datw[i] = '0; sel[i] = '0;
        end

        // reset state
        check_all();
        check("rst_gnt", a_gnt, 2'b00);
        check("rst_s_cyc", a_s_cyc, 1'b0);
        tick();
        cycle();
        rst = 1'b0;

        // single m0 write
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
        adr[0] = 32'h10; datw[0] = 32'hDEADBEEF; sel[0] = 4'hF;
        cycle();
        check_all();
        check("wr_gnt", a_gnt, 2'b01);
        check("wr_adr", a_s_adr, 32'h10);
        check("wr_dat", a_s_dat_w, 32'hDEADBEEF);
        tick();
        s_ack = 1'b1;
        check_all();
        check("wr_m0_ack", a_m0_ack, 1'b1);
        check("wr_m1_ack", a_m1_ack, 1'b0);
        tick();
        cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
        cycle();
        cycle();

        // contention after reset, handover, alternation
        do_reset();
        cyc = 2'b11; stb = 2'b11;
        cycle();
        check_all();
        check("c1_gnt", a_gnt, 2'b01);
        tick();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        cycle();
        check_all();
        check("c2_gnt", a_gnt, 2'b10);
        tick();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cycle();
        cyc[1] = 1'b0; stb[1] = 1'b0;
        cycle();
        check_all();
        check("c3_gnt", a_gnt, 2'b01);
        tick();
        cyc = 2'b00; stb = 2'b00;
        cycle();

        // timeout: slave never answers, m0 holds STB
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cycle();
        errb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_all();
            errv[k] = a_m0_err;
            errb    = errb | b_m0_err;
            tick();
        end
        check("to_pattern", errv, 8'b1000_1000);
        check("to0_none", errb, 1'b0);

        // reset mid-burst while m1 owns the bus
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; s_ack = 1'b1;
        cycle();
        check_all();
        check("rb_gnt", a_gnt, 2'b10);
        check("rb_stb", a_s_stb, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rb_s_cyc", a_s_cyc, 1'b0);
        check("rb_s_stb", a_s_stb, 1'b0);
        check("rb_m1_ack", a_m1_ack, 1'b0);
        check("rb_gnt0", a_gnt, 2'b00);
        check("rb_b_gnt0", b_gnt, 2'b00);
        tick();
        cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
        cycle();
        rst = 1'b0;
        cyc = 2'b11; stb = 2'b11;
        cycle();
        check_all();
        check("pr_gnt", a_gnt, 2'b01);
        tick();

        // randomized traffic with a responsive slave, then a silent one
        do_reset();
        repeat (400) begin
            rand_inputs(40, 75);
            cycle();
        end
        repeat (250) begin
            rand_inputs(0, 95);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
